// File: rtl/hazard_pkg.sv
// Hazard controller shared types: FSM states, forwarding selects,
// register-0 constant and the producer/consumer match helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $0 is hard-wired, so it never produces a dependency
  function automatic logic reg_match(
    input logic [4:0] src,
    input logic [4:0] dest,
    input logic       en
  );
    return en && (dest != REG_ZERO) && (src == dest);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: pipeline status in, stall/flush/forward out.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_uses_src2;
  logic [4:0]       exe_src1;
  logic [4:0]       exe_src2;
  logic [4:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic             br_taken;
  logic [4:0]       mem_dest;
  logic             mem_wb_en;
  logic             mem_r_en;
  logic             mem_w_en;
  logic             mem_ready;
  logic [4:0]       wb_dest;
  logic             wb_en;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_freeze;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_uses_src2,
    output exe_src1, exe_src2, exe_dest, exe_wb_en,
    output exe_mem_r_en, br_taken,
    output mem_dest, mem_wb_en, mem_r_en, mem_w_en,
    output mem_ready, wb_dest, wb_en,
    input  pc_stall, ifid_stall, ifid_flush, idex_flush,
    input  pipe_freeze, fwd_a_sel, fwd_b_sel,
    input  mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_uses_src2,
    input  exe_src1, exe_src2, exe_dest, exe_wb_en,
    input  exe_mem_r_en, br_taken,
    input  mem_dest, mem_wb_en, mem_r_en, mem_w_en,
    input  mem_ready, wb_dest, wb_en,
    output pc_stall, ifid_stall, ifid_flush, idex_flush,
    output pipe_freeze, fwd_a_sel, fwd_b_sel,
    output mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// EXE operand forwarding select for one source register.
// i_src vs EX/MEM and MEM/WB producers -> o_sel (FWD_RF/MEM/WB).
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic [4:0] i_mem_dest,
  input  logic       i_mem_wb_en,
  input  logic [4:0] i_wb_dest,
  input  logic       i_wb_en,
  output logic [1:0] o_sel
);

  // younger producer (EX/MEM) wins over MEM/WB
  always_comb begin
    o_sel = FWD_RF;
    if (reg_match(i_src, i_mem_dest, i_mem_wb_en))
      o_sel = FWD_MEM;
    else if (reg_match(i_src, i_wb_dest, i_wb_en))
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard/sequencing controller: stalls, flushes,
// memory freeze with watchdog, forwarding selects, perf counters.
// Ports: clk, rst (sync, active-high), hz (pipe_hazard_ctrl_if.slave).
// Macro FORWARD_EN: enable EXE forwarding (only load-use stalls);
// without it any ID source hit in EXE or MEM stalls until it drains.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   hz
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);

  hz_state_t        r_state;
  logic [WD_W-1:0]  r_wd;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_mem_busy;
  logic             w_freeze;
  logic             w_id_hit_exe;
  logic             w_hazard;
  logic             w_run;
  logic             w_br;
  logic             w_stall;
  logic [1:0]       w_fa;
  logic [1:0]       w_fb;
  logic [WD_W-1:0]  w_wd_nxt;

  assign w_mem_busy = (hz.mem_r_en | hz.mem_w_en) & ~hz.mem_ready;
  assign w_wd_nxt   = r_wd + 1'b1;

  // RUN freezes on the first cycle of a stalled access, not one later
  always_comb begin
    w_freeze = 1'b0;
    unique case (r_state)
      RUN:      w_freeze = w_mem_busy;
      MEM_WAIT: w_freeze = ~hz.mem_ready;
      ERR:      w_freeze = 1'b1;
      default:  w_freeze = 1'b0;
    endcase
  end

  assign w_id_hit_exe = hz.id_valid &
    (reg_match(hz.id_src1, hz.exe_dest, hz.exe_wb_en) |
     (hz.id_uses_src2 &
      reg_match(hz.id_src2, hz.exe_dest, hz.exe_wb_en)));

`ifdef FORWARD_EN
  assign w_hazard = w_id_hit_exe & hz.exe_mem_r_en;

  hazard_fwd_unit u_fwd_a (
    .i_src       (hz.exe_src1),
    .i_mem_dest  (hz.mem_dest),
    .i_mem_wb_en (hz.mem_wb_en),
    .i_wb_dest   (hz.wb_dest),
    .i_wb_en     (hz.wb_en),
    .o_sel       (w_fa)
  );

  hazard_fwd_unit u_fwd_b (
    .i_src       (hz.exe_src2),
    .i_mem_dest  (hz.mem_dest),
    .i_mem_wb_en (hz.mem_wb_en),
    .i_wb_dest   (hz.wb_dest),
    .i_wb_en     (hz.wb_en),
    .o_sel       (w_fb)
  );
`else
  logic w_id_hit_mem;
  logic w_unused;

  assign w_id_hit_mem = hz.id_valid &
    (reg_match(hz.id_src1, hz.mem_dest, hz.mem_wb_en) |
     (hz.id_uses_src2 &
      reg_match(hz.id_src2, hz.mem_dest, hz.mem_wb_en)));

  // producer must reach WB before the consumer may read the RF
  assign w_hazard = w_id_hit_exe | w_id_hit_mem;
  assign w_fa     = FWD_RF;
  assign w_fb     = FWD_RF;
  assign w_unused = ^{hz.exe_src1, hz.exe_src2, hz.wb_dest,
                      hz.wb_en, hz.exe_mem_r_en};
`endif

  // a branch held by a frozen ID/EX fires on the first free cycle
  assign w_run   = ~rst & ~w_freeze;
  assign w_br    = w_run & hz.br_taken;
  assign w_stall = w_run & w_hazard & ~hz.br_taken;

  assign hz.pc_stall    = w_stall;
  assign hz.ifid_stall  = w_stall;
  assign hz.ifid_flush  = w_br;
  assign hz.idex_flush  = w_br | w_stall;
  assign hz.pipe_freeze = ~rst & w_freeze;
  assign hz.fwd_a_sel   = w_run ? w_fa : FWD_RF;
  assign hz.fwd_b_sel   = w_run ? w_fb : FWD_RF;
  assign hz.mem_err     = r_mem_err;
  assign hz.stall_cnt   = r_stall_cnt;
  assign hz.flush_cnt   = r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wd        <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_mem_busy) begin
            r_state <= MEM_WAIT;
            r_wd    <= '0;
          end
        end
        MEM_WAIT: begin
          if (hz.mem_ready) begin
            r_state <= RUN;
            r_wd    <= '0;
          end else if (w_wd_nxt == WD_MAX) begin
            r_state   <= ERR;
            r_mem_err <= 1'b1;
            r_wd      <= w_wd_nxt;
          end else begin
            r_wd <= w_wd_nxt;
          end
        end
        ERR:     r_state <= ERR;
        default: r_state <= RUN;
      endcase

      if ((w_stall | w_freeze) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_br && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int TMO   = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  function automatic bit mt(int s, int d, bit en);
    return en && (d != 0) && (s == d);
  endfunction

  task automatic idle();
    hz.id_valid = 0; hz.id_src1 = 0; hz.id_src2 = 0;
    hz.id_uses_src2 = 0; hz.exe_src1 = 0; hz.exe_src2 = 0;
    hz.exe_dest = 0; hz.exe_wb_en = 0; hz.exe_mem_r_en = 0;
    hz.br_taken = 0; hz.mem_dest = 0; hz.mem_wb_en = 0;
    hz.mem_r_en = 0; hz.mem_w_en = 0; hz.mem_ready = 1;
    hz.wb_dest = 0; hz.wb_en = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_use(int r);
    hz.exe_mem_r_en = 1; hz.exe_wb_en = 1; hz.exe_dest = 5'(r);
    hz.id_valid = 1; hz.id_src1 = 5'(r);
  endtask

  task automatic test_reset();
    logic [8:0] v;
    rst = 1'b1;
    load_use(8);
    hz.br_taken = 1; hz.mem_r_en = 1; hz.mem_ready = 0;
    hz.exe_src1 = 5; hz.mem_dest = 5; hz.mem_wb_en = 1;
    #1;
    v = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_flush,
         hz.pipe_freeze, hz.fwd_a_sel, hz.fwd_b_sel};
    n_chk++;
    if (v !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0", v);
    end
    tick();
    n_chk++;
    if ({hz.mem_err, hz.stall_cnt, hz.flush_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: err %b stall %0d flush %0d want 0",
               hz.mem_err, hz.stall_cnt, hz.flush_cnt);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    load_use(8);
    #1;
    n_chk++;
    if ({hz.pc_stall, hz.ifid_stall, hz.idex_flush, hz.ifid_flush}
        !== 4'b1110) begin
      n_fail++;
      $display("FAIL lu_stall: got %b%b%b%b want 1110", hz.pc_stall,
               hz.ifid_stall, hz.idex_flush, hz.ifid_flush);
    end
    tick();
    // load now in MEM, ID still reads $8
    hz.exe_mem_r_en = 0; hz.exe_wb_en = 0; hz.exe_dest = 0;
    hz.mem_dest = 8; hz.mem_wb_en = 1; hz.mem_r_en = 1;
    #1;
    n_chk++;
    if (hz.pc_stall !== !FWD) begin
      n_fail++;
      $display("FAIL lu_second: got %b want %b", hz.pc_stall, !FWD);
    end
    n_chk++;
    if (hz.stall_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL lu_cnt: got %0d want 1", hz.stall_cnt);
    end
    idle();
  endtask

  task automatic test_branch_lu();
    do_reset();
    load_use(8);
    hz.br_taken = 1;
    #1;
    n_chk++;
    if ({hz.ifid_flush, hz.idex_flush, hz.pc_stall, hz.ifid_stall}
        !== 4'b1100) begin
      n_fail++;
      $display("FAIL br_lu: got %b%b%b%b want 1100", hz.ifid_flush,
               hz.idex_flush, hz.pc_stall, hz.ifid_stall);
    end
    tick();
    idle();
    #1;
    n_chk++;
    if ({hz.flush_cnt, hz.stall_cnt, hz.ifid_flush} !== {4'd1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL br_cnt: flush %0d stall %0d f %b want 1 0 0",
               hz.flush_cnt, hz.stall_cnt, hz.ifid_flush);
    end
  endtask

  task automatic test_forward();
    do_reset();
    hz.exe_src1 = 5; hz.mem_dest = 5; hz.mem_wb_en = 1;
    hz.wb_dest = 5; hz.wb_en = 1; hz.exe_src2 = 0;
    #1;
    n_chk++;
    if (hz.fwd_a_sel !== (FWD ? 2'd1 : 2'd0)) begin
      n_fail++;
      $display("FAIL fwd_mem: got %0d want %0d", hz.fwd_a_sel, FWD);
    end
    n_chk++;
    if (hz.fwd_b_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL fwd_r0: got %0d want 0", hz.fwd_b_sel);
    end
    hz.exe_src1 = 0; hz.exe_src2 = 5; hz.mem_wb_en = 0;
    #1;
    n_chk++;
    if ({hz.fwd_a_sel, hz.fwd_b_sel} !== {2'd0, FWD ? 2'd2 : 2'd0}) begin
      n_fail++;
      $display("FAIL fwd_wb: got %0d/%0d want 0/%0d",
               hz.fwd_a_sel, hz.fwd_b_sel, FWD ? 2 : 0);
    end
    hz.mem_r_en = 1; hz.mem_ready = 0;
    #1;
    n_chk++;
    if (hz.fwd_b_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL fwd_freeze: got %0d want 0", hz.fwd_b_sel);
    end
    idle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    hz.mem_r_en = 1; hz.mem_ready = 0; hz.br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if ({hz.pipe_freeze, hz.ifid_flush, hz.idex_flush} !== 3'b100) begin
        n_fail++;
        $display("FAIL mw_freeze%0d: got %b%b%b want 100", i,
                 hz.pipe_freeze, hz.ifid_flush, hz.idex_flush);
      end
      tick();
    end
    hz.mem_ready = 1;
    #1;
    n_chk++;
    if ({hz.pipe_freeze, hz.ifid_flush} !== 2'b01) begin
      n_fail++;
      $display("FAIL mw_release: got %b%b want 01",
               hz.pipe_freeze, hz.ifid_flush);
    end
    tick();
    idle();
    #1;
    n_chk++;
    if ({hz.stall_cnt, hz.flush_cnt, hz.pipe_freeze} !== {4'd3, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL mw_cnt: stall %0d flush %0d fr %b want 3 1 0",
               hz.stall_cnt, hz.flush_cnt, hz.pipe_freeze);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    hz.mem_w_en = 1; hz.mem_ready = 0;
    // one RUN entry cycle, then TMO cycles in the wait state
    for (int i = 1; i <= TMO + 2; i++) begin
      #1;
      n_chk++;
      if (hz.pipe_freeze !== 1'b1) begin
        n_fail++;
        $display("FAIL to_freeze%0d: got %b want 1", i, hz.pipe_freeze);
      end
      tick();
      n_chk++;
      if (hz.mem_err !== (i >= TMO + 1)) begin
        n_fail++;
        $display("FAIL to_err%0d: got %b want %b", i, hz.mem_err,
                 i >= TMO + 1);
      end
    end
    hz.mem_ready = 1;
    #1;
    n_chk++;
    if ({hz.pipe_freeze, hz.stall_cnt} !== {1'b1, 4'(TMO + 2)}) begin
      n_fail++;
      $display("FAIL to_hold: fr %b stall %0d want 1 %0d",
               hz.pipe_freeze, hz.stall_cnt, TMO + 2);
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if ({hz.pipe_freeze, hz.mem_err, hz.stall_cnt} !== '0) begin
      n_fail++;
      $display("FAIL to_rst: fr %b err %b stall %0d want 0",
               hz.pipe_freeze, hz.mem_err, hz.stall_cnt);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_raw_nofwd();
    int st;
    do_reset();
    st = 0;
    hz.id_valid = 1; hz.id_src2 = 3; hz.id_uses_src2 = 1;
    hz.exe_dest = 3; hz.exe_wb_en = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (hz.pc_stall === 1'b1) st++;
      tick();
      hz.exe_wb_en = 0; hz.exe_dest = 0;
      hz.mem_wb_en = (c == 0); hz.mem_dest = (c == 0) ? 5'd3 : 5'd0;
      hz.wb_en = (c == 1); hz.wb_dest = (c == 1) ? 5'd3 : 5'd0;
    end
    n_chk++;
    if (st !== (FWD ? 0 : 2)) begin
      n_fail++;
      $display("FAIL raw_stalls: got %0d want %0d", st, FWD ? 0 : 2);
    end
    hz.exe_dest = 0; hz.exe_wb_en = 1; hz.id_src1 = 0;
    hz.id_src2 = 0; hz.exe_mem_r_en = 1;
    #1;
    n_chk++;
    if (hz.pc_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_r0: got %b want 0", hz.pc_stall);
    end
    idle();
  endtask

  task automatic test_saturate();
    do_reset();
    load_use(9);
    hz.br_taken = 0;
    repeat (SAT + 5) tick();
    hz.br_taken = 1;
    repeat (SAT + 5) tick();
    #1;
    n_chk++;
    if ({hz.stall_cnt, hz.flush_cnt} !== {4'(SAT), 4'(SAT)}) begin
      n_fail++;
      $display("FAIL sat: stall %0d flush %0d want %0d",
               hz.stall_cnt, hz.flush_cnt, SAT);
    end
    idle();
  endtask

  task automatic test_random();
    bit m_err, m_pend;
    int m_wait, m_stall, m_flush;
    bit acc, frz, hit_e, hit_m, haz, e_br, e_st;
    int e_fa, e_fb;
    logic [4:0] e_ctrl;
    do_reset();
    m_err = 0; m_pend = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (m_err) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_err = 0; m_pend = 0; m_stall = 0; m_flush = 0;
      end
      hz.id_valid = ($urandom_range(0, 7) != 0);
      hz.id_src1 = 5'($urandom_range(0, 3));
      hz.id_src2 = 5'($urandom_range(0, 3));
      hz.id_uses_src2 = 1'($urandom);
      hz.exe_src1 = 5'($urandom_range(0, 3));
      hz.exe_src2 = 5'($urandom_range(0, 3));
      hz.exe_dest = 5'($urandom_range(0, 3));
      hz.exe_wb_en = 1'($urandom);
      hz.exe_mem_r_en = 1'($urandom);
      hz.br_taken = ($urandom_range(0, 5) == 0);
      hz.mem_dest = 5'($urandom_range(0, 3));
      hz.mem_wb_en = 1'($urandom);
      hz.wb_dest = 5'($urandom_range(0, 3));
      hz.wb_en = 1'($urandom);
      hz.mem_ready = 1'($urandom);
      if (!m_pend) begin
        hz.mem_r_en = ($urandom_range(0, 3) == 0);
        hz.mem_w_en = ($urandom_range(0, 5) == 0);
      end
      acc = hz.mem_r_en || hz.mem_w_en;
      frz = m_err || (acc && !hz.mem_ready);
      hit_e = hz.id_valid &&
        (mt(hz.id_src1, hz.exe_dest, hz.exe_wb_en) ||
         (hz.id_uses_src2 && mt(hz.id_src2, hz.exe_dest, hz.exe_wb_en)));
      hit_m = hz.id_valid &&
        (mt(hz.id_src1, hz.mem_dest, hz.mem_wb_en) ||
         (hz.id_uses_src2 && mt(hz.id_src2, hz.mem_dest, hz.mem_wb_en)));
      haz = FWD ? (hit_e && hz.exe_mem_r_en) : (hit_e || hit_m);
      e_br = !frz && hz.br_taken;
      e_st = !frz && haz && !hz.br_taken;
      e_fa = 0; e_fb = 0;
      if (FWD && !frz) begin
        e_fa = mt(hz.exe_src1, hz.mem_dest, hz.mem_wb_en) ? 1 :
               mt(hz.exe_src1, hz.wb_dest, hz.wb_en) ? 2 : 0;
        e_fb = mt(hz.exe_src2, hz.mem_dest, hz.mem_wb_en) ? 1 :
               mt(hz.exe_src2, hz.wb_dest, hz.wb_en) ? 2 : 0;
      end
      e_ctrl = {e_st, e_st, e_br, e_br || e_st, frz};
      #1;
      n_chk++;
      if ({hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_flush,
           hz.pipe_freeze} !== e_ctrl) begin
        n_fail++;
        $display("FAIL rnd_ctrl c%0d: got %b%b%b%b%b want %b", cyc,
                 hz.pc_stall, hz.ifid_stall, hz.ifid_flush,
                 hz.idex_flush, hz.pipe_freeze, e_ctrl);
      end
      n_chk++;
      if ({hz.fwd_a_sel, hz.fwd_b_sel} !== {2'(e_fa), 2'(e_fb)}) begin
        n_fail++;
        $display("FAIL rnd_fwd c%0d: got %0d/%0d want %0d/%0d", cyc,
                 hz.fwd_a_sel, hz.fwd_b_sel, e_fa, e_fb);
      end
      n_chk++;
      if ({hz.mem_err, hz.stall_cnt, hz.flush_cnt} !==
          {m_err, 4'(m_stall), 4'(m_flush)}) begin
        n_fail++;
        $display("FAIL rnd_regs c%0d: err %b st %0d fl %0d want %b %0d %0d",
                 cyc, hz.mem_err, hz.stall_cnt, hz.flush_cnt,
                 m_err, m_stall, m_flush);
      end
      if ((e_st || frz) && m_stall < SAT) m_stall++;
      if (e_br && m_flush < SAT) m_flush++;
      if (acc && !hz.mem_ready) begin
        if (m_pend) begin
          m_wait++;
          if (m_wait == TMO) m_err = 1;
        end else begin
          m_pend = 1;
          m_wait = 0;
        end
      end else begin
        m_pend = 0;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    test_reset();
    test_load_use();
    test_branch_lu();
    test_forward();
    test_mem_wait();
    test_timeout();
    test_raw_nofwd();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
